// File: rtl/power_window_accum.sv
// Squares signed samples, sums them over 2^WINDOW_LOG2 accepted samples, and issues the saturated
// 20-bit power with a strobe that is rate-limited by a holdoff counter.
module power_window_accum #(
  parameter int SAMPLE_BITS = 8,
  parameter int WINDOW_LOG2 = 4,
  parameter int HOLDOFF     = 21
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic signed [SAMPLE_BITS-1:0] dat_i,
  input  logic                          dat_valid_i,
  input  logic                          clr_overrun_i,
  output logic [19:0]                   pow_o,
  output logic                          calc_o,
  output logic                          pending_o,
  output logic                          overrun_o
);

  localparam int SQ_W  = 2 * SAMPLE_BITS;
  localparam int ACC_W = SQ_W + WINDOW_LOG2;
  localparam int HO_W  = $clog2(HOLDOFF + 1);

  logic signed [SQ_W-1:0]  prod;
  logic [SQ_W-1:0]         sq_q;
  logic                    sq_vld_q;
  logic [ACC_W-1:0]        acc_q;
  logic [ACC_W-1:0]        sum;
  logic [WINDOW_LOG2-1:0]  cnt_q;
  logic [19:0]             sat;
  logic [19:0]             result_q;
  logic [HO_W-1:0]         holdoff_q;
  logic                    win_end;
  logic                    issue;

  // Operands are sign-extended to the product width, so the square is exact.
  assign prod = dat_i * dat_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sq_q     <= '0;
      sq_vld_q <= 1'b0;
    end else begin
      sq_q     <= $unsigned(prod);
      sq_vld_q <= dat_valid_i;
    end
  end

  assign sum     = acc_q + ACC_W'(sq_q);
  assign win_end = sq_vld_q && (cnt_q == {WINDOW_LOG2{1'b1}});
  assign issue   = pending_o && (holdoff_q == '0);

  generate
    if (ACC_W > 20) begin : g_sat
      assign sat = (|sum[ACC_W-1:20]) ? 20'hFFFFF : sum[19:0];
    end else begin : g_nosat
      assign sat = 20'(sum);
    end
  endgenerate

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (win_end) begin
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= sat;
    end else if (sq_vld_q) begin
      acc_q <= sum;
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // A window ending on the issue edge refills the result register, so pending stays set.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pow_o     <= '0;
      calc_o    <= 1'b0;
      pending_o <= 1'b0;
      overrun_o <= 1'b0;
      holdoff_q <= '0;
    end else begin
      calc_o <= issue;
      if (issue) begin
        pow_o     <= result_q;
        holdoff_q <= HO_W'(HOLDOFF - 1);
      end else if (holdoff_q != '0) begin
        holdoff_q <= holdoff_q - 1'b1;
      end

      if (win_end)    pending_o <= 1'b1;
      else if (issue) pending_o <= 1'b0;

      if (win_end && pending_o && !issue) overrun_o <= 1'b1;
      else if (clr_overrun_i)             overrun_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_power_window_accum.sv
// Directed bench for power_window_accum: one task per scenario, inline comparisons against
// hand-computed expected values.
module tb_power_window_accum;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b1;
  logic signed [7:0] dat_i = '0;
  logic              dat_valid_i = 1'b0;
  logic              clr_overrun_i = 1'b0;
  logic [19:0]       pow_o;
  logic              calc_o;
  logic              pending_o;
  logic              overrun_o;

  int checks = 0;
  int errors = 0;

  power_window_accum dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .dat_i         (dat_i),
    .dat_valid_i   (dat_valid_i),
    .clr_overrun_i (clr_overrun_i),
    .pow_o         (pow_o),
    .calc_o        (calc_o),
    .pending_o     (pending_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    rst_i = 1'b1;
    dat_valid_i = 1'b0;
    clr_overrun_i = 1'b0;
    dat_i = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    #3;
    checks++;
    if ({pow_o, calc_o, pending_o, overrun_o} !== 23'd0) begin
      errors++;
      $display("FAIL reset_state: got pow=%0d calc=%b pend=%b ovr=%b, want all 0",
               pow_o, calc_o, pending_o, overrun_o);
    end
    do_reset();
  endtask

  // Cycle i starts at the i-th posedge after reset; inputs driven in cycle i are captured at its end.
  task automatic test_single_window();
    do_reset();
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_i); #1;
      if (i >= 15) begin
        checks++;
        if (pending_o !== (i == 17)) begin
          errors++;
          $display("FAIL single_pending cyc %0d: got %b want %b", i, pending_o, (i == 17));
        end
        checks++;
        if (calc_o !== (i == 18)) begin
          errors++;
          $display("FAIL single_calc cyc %0d: got %b want %b", i, calc_o, (i == 18));
        end
        checks++;
        if (pow_o !== ((i >= 18) ? 20'd160000 : 20'd0)) begin
          errors++;
          $display("FAIL single_pow cyc %0d: got %0d want %0d", i, pow_o,
                   (i >= 18) ? 160000 : 0);
        end
      end
      dat_valid_i = (i < 16);
      dat_i = 8'sd100;
    end
    checks++;
    if (overrun_o !== 1'b0) begin
      errors++;
      $display("FAIL single_overrun: got %b want 0", overrun_o);
    end
  endtask

  task automatic test_gaps();
    int accepted = 0;
    bit seen = 1'b0;
    do_reset();
    for (int i = 0; i < 200 && accepted < 16; i++) begin
      @(posedge clk_i); #1;
      if ($urandom_range(0, 2) != 0) begin
        dat_valid_i = 1'b1;
        dat_i = 8'h80;
        accepted++;
      end else begin
        dat_valid_i = 1'b0;
        dat_i = 8'sd127;
      end
    end
    @(posedge clk_i); #1;
    dat_valid_i = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (calc_o) begin
        seen = 1'b1;
        checks++;
        if (pow_o !== 20'd262144) begin
          errors++;
          $display("FAIL gaps_pow: got %0d want 262144", pow_o);
        end
      end else begin
        @(posedge clk_i); #1;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL gaps_timeout: got no calc strobe, want one");
    end
  endtask

  task automatic test_back_to_back();
    bit exp_calc;
    bit exp_ovr;
    do_reset();
    for (int i = 0; i <= 130; i++) begin
      @(posedge clk_i); #1;
      exp_calc = (i == 18) || (i == 39) || (i == 60) || (i == 81) || (i == 102);
      exp_ovr  = (i >= 97) && (i <= 100);
      checks++;
      if (calc_o !== exp_calc) begin
        errors++;
        $display("FAIL b2b_calc cyc %0d: got %b want %b", i, calc_o, exp_calc);
      end
      if (calc_o) begin
        checks++;
        if (pow_o !== 20'd16) begin
          errors++;
          $display("FAIL b2b_pow cyc %0d: got %0d want 16", i, pow_o);
        end
      end
      checks++;
      if (overrun_o !== exp_ovr) begin
        errors++;
        $display("FAIL b2b_overrun cyc %0d: got %b want %b", i, overrun_o, exp_ovr);
      end
      dat_valid_i = (i < 96);
      dat_i = 8'sd1;
      clr_overrun_i = (i == 100);
    end
    clr_overrun_i = 1'b0;
  endtask

  task automatic test_idle_windows();
    bit [19:0] exp_pow;
    do_reset();
    for (int i = 0; i <= 62; i++) begin
      @(posedge clk_i); #1;
      exp_pow = (i >= 59) ? 20'd400 : (i >= 18) ? 20'd144 : 20'd0;
      checks++;
      if (calc_o !== ((i == 18) || (i == 59))) begin
        errors++;
        $display("FAIL idle_calc cyc %0d: got %b want %b", i, calc_o, (i == 18) || (i == 59));
      end
      checks++;
      if (pow_o !== exp_pow) begin
        errors++;
        $display("FAIL idle_pow cyc %0d: got %0d want %0d", i, pow_o, exp_pow);
      end
      if (i < 16) begin
        dat_valid_i = 1'b1;
        dat_i = 8'sd3;
      end else if (i >= 41 && i <= 56) begin
        dat_valid_i = 1'b1;
        dat_i = -8'sd5;
      end else begin
        dat_valid_i = 1'b0;
      end
    end
    dat_valid_i = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_i); #1;
      if (i == 20) begin
        checks++;
        if (pow_o !== 20'd16) begin
          errors++;
          $display("FAIL areset_pre_pow: got %0d want 16", pow_o);
        end
      end
      dat_valid_i = (i < 16) || (i >= 20);
      dat_i = (i < 16) ? 8'sd1 : 8'sd9;
    end
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({pow_o, calc_o, pending_o, overrun_o} !== 23'd0) begin
      errors++;
      $display("FAIL areset_outputs: got pow=%0d calc=%b pend=%b ovr=%b, want all 0",
               pow_o, calc_o, pending_o, overrun_o);
    end
    dat_valid_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk_i); #1;
      if (i >= 17) begin
        checks++;
        if (calc_o !== (i == 18)) begin
          errors++;
          $display("FAIL areset_calc cyc %0d: got %b want %b", i, calc_o, (i == 18));
        end
      end
      if (i == 18) begin
        checks++;
        if (pow_o !== 20'd64) begin
          errors++;
          $display("FAIL areset_pow: got %0d want 64", pow_o);
        end
      end
      dat_valid_i = (i < 16);
      dat_i = 8'sd2;
    end
    dat_valid_i = 1'b0;
  endtask

  task automatic test_clear_collision();
    bit exp_ovr;
    do_reset();
    for (int i = 0; i <= 100; i++) begin
      @(posedge clk_i); #1;
      exp_ovr = (i == 97) || (i == 98);
      checks++;
      if (overrun_o !== exp_ovr) begin
        errors++;
        $display("FAIL collide_overrun cyc %0d: got %b want %b", i, overrun_o, exp_ovr);
      end
      dat_valid_i = (i < 96);
      dat_i = 8'sd1;
      clr_overrun_i = (i <= 96) || (i == 98);
    end
    clr_overrun_i = 1'b0;
    dat_valid_i = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_gaps();
    test_back_to_back();
    test_idle_windows();
    test_async_reset();
    test_clear_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
